dmem_master: RTL and testbench

- Initiator side of the processor data-memory interface: the MEM stage hands one load/store request to this block, which drives addr/write_data/memread/memwrite/sign_mask into the data memory and tracks its clk_stall handshake.
- Returns a response pulse carrying the load data or a fault.
- Splits misaligned loads into two aligned word reads and merges them; misaligned stores, address wrap and stalled-memory timeouts are reported as faults.

---
 rtl/dmem_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_dmem_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_master
//   Initiator side of the processor data-memory interface. The MEM stage hands
//   over one load/store request at a time. This block drives the data-memory
//   strobes, follows its clk_stall handshake and returns a one-cycle response
//   carrying the load data or a fault. Misaligned loads are split into two
//   aligned word reads and merged here. Misaligned stores, base-address wrap
//   and a memory that never completes its handshake are reported as faults.
//
// Ports
//   clk, rst_n            clock (posedge) / synchronous active-low reset
//   i_req_*, o_req_ready  request channel (valid/ready handshake)
//   o_resp_*              one-cycle response pulse: rdata + fault
//   o_mem_*               address, write data, strobes and sign_mask to memory
//   i_mem_clk_stall       memory busy flag (rises after a strobe, then falls)
//   i_mem_read_data       memory read data, valid once stall has fallen
// -----------------------------------------------------------------------------
module dmem_master #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_sign_mask,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_fault,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_write_data,
    output logic        o_mem_memread,
    output logic        o_mem_memwrite,
    output logic [2:0]  o_mem_sign_mask,
    input  logic        i_mem_clk_stall,
    input  logic [31:0] i_mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_ISSUE2,
        S_WAIT2_HI,
        S_WAIT2_LO,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic        r_fault;
    logic        r_split;
    logic [1:0]  r_off;
    logic [2:0]  r_mask;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_mem_mask;
    logic [31:0] r_w0;
    logic [31:0] r_rdata;
    logic [CNT_W-1:0] r_wdog;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_wrap;
    logic        w_acc_fault;
    logic        w_acc_split;
    logic        w_in_wait;
    logic        w_wdog_hit;
    logic        w_timeout;
    logic        w_lo_done;
    logic        w_lo2_done;

    // Merge two aligned words into the misaligned result. Only word and
    // halfword accesses can be split, so byte handling is not needed here.
    function automatic logic [31:0] f_merge(input logic [31:0] w0,
                                            input logic [31:0] w1,
                                            input logic [1:0]  off,
                                            input logic [2:0]  mask);
        logic [63:0] pair;
        logic [31:0] res;
        pair = {w1, w0} >> {off, 3'b000};
        if (mask[1]) begin
            res = pair[31:0];
        end else if (mask[2]) begin
            res = {{16{pair[15]}}, pair[15:0]};
        end else begin
            res = {16'h0000, pair[15:0]};
        end
        return res;
    endfunction

    // Request classification, evaluated on the accepting edge.
    always_comb begin
        w_misaligned = 1'b0;
        if (i_req_sign_mask[1]) begin
            w_misaligned = (i_req_addr[1:0] != 2'b00);
        end else if (i_req_sign_mask[0]) begin
            w_misaligned = (i_req_addr[1:0] == 2'b11);
        end
        // A split read of the last word would need base+4, which wraps to 0.
        w_wrap      = (i_req_addr[31:2] == 30'h3FFF_FFFF);
        w_acc_fault = w_misaligned & (i_req_write | w_wrap);
        w_acc_split = w_misaligned & ~i_req_write & ~w_wrap;
    end

    // Next state and strobes.
    always_comb begin
        w_next         = r_state;
        w_timeout      = 1'b0;
        o_mem_memread  = 1'b0;
        o_mem_memwrite = 1'b0;
        // Stall is checked even in IDLE: after a reset or timeout the memory
        // may still be finishing a cycle we no longer track.
        o_req_ready    = (r_state == S_IDLE) & ~i_mem_clk_stall;
        w_accept       = i_req_valid & o_req_ready;
        w_in_wait      = (r_state == S_WAIT_HI)  | (r_state == S_WAIT_LO) |
                         (r_state == S_WAIT2_HI) | (r_state == S_WAIT2_LO);
        w_wdog_hit     = (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1));
        w_lo_done      = (r_state == S_WAIT_LO)  & ~i_mem_clk_stall;
        w_lo2_done     = (r_state == S_WAIT2_LO) & ~i_mem_clk_stall;

        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                // Faulted requests pass through without touching memory.
                o_mem_memread  = ~r_fault & ~r_write;
                o_mem_memwrite = ~r_fault & r_write;
                w_next         = r_fault ? S_RESP : S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (i_mem_clk_stall) begin
                    w_next = S_WAIT_LO;
                end else if (w_wdog_hit) begin
                    w_next    = S_RESP;
                    w_timeout = 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!i_mem_clk_stall) begin
                    w_next = r_split ? S_ISSUE2 : S_RESP;
                end else if (w_wdog_hit) begin
                    w_next    = S_RESP;
                    w_timeout = 1'b1;
                end
            end
            S_ISSUE2: begin
                o_mem_memread = 1'b1;
                w_next        = S_WAIT2_HI;
            end
            S_WAIT2_HI: begin
                if (i_mem_clk_stall) begin
                    w_next = S_WAIT2_LO;
                end else if (w_wdog_hit) begin
                    w_next    = S_RESP;
                    w_timeout = 1'b1;
                end
            end
            S_WAIT2_LO: begin
                if (!i_mem_clk_stall) begin
                    w_next = S_RESP;
                end else if (w_wdog_hit) begin
                    w_next    = S_RESP;
                    w_timeout = 1'b1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_fault     <= 1'b0;
            r_split     <= 1'b0;
            r_off       <= 2'b00;
            r_mask      <= 3'b000;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_mask  <= 3'b000;
            r_w0        <= 32'h0;
            r_rdata     <= 32'h0;
            r_wdog      <= '0;
        end else begin
            r_state <= w_next;

            if (w_next != r_state) begin
                r_wdog <= '0;
            end else if (w_in_wait) begin
                r_wdog <= r_wdog + CNT_W'(1);
            end

            if (w_accept) begin
                r_write     <= i_req_write;
                r_fault     <= w_acc_fault;
                r_split     <= w_acc_split;
                r_off       <= i_req_addr[1:0];
                r_mask      <= i_req_sign_mask;
                r_mem_addr  <= w_acc_split ? {i_req_addr[31:2], 2'b00} : i_req_addr;
                r_mem_mask  <= w_acc_split ? 3'b010 : i_req_sign_mask;
                r_mem_wdata <= i_req_wdata;
                r_rdata     <= 32'h0;
            end

            if (w_timeout) begin
                r_fault <= 1'b1;
                r_rdata <= 32'h0;
            end

            // First half of a split lands in r_w0; the address moves to the
            // second word only once the first read has fully completed.
            if (w_lo_done) begin
                if (r_split) begin
                    r_w0       <= i_mem_read_data;
                    r_mem_addr <= r_mem_addr + 32'd4;
                end else if (!r_write) begin
                    r_rdata <= i_mem_read_data;
                end
            end

            if (w_lo2_done) begin
                r_rdata <= f_merge(r_w0, i_mem_read_data, r_off, r_mask);
            end
        end
    end

    assign o_resp_valid     = (r_state == S_RESP);
    assign o_resp_fault     = (r_state == S_RESP) & r_fault;
    assign o_resp_rdata     = r_rdata;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_write_data = r_mem_wdata;
    assign o_mem_sign_mask  = r_mem_mask;

endmodule

// File: tb/tb_dmem_master.sv
`timescale 1ns/1ps
// Testbench for dmem_master: table of directed request vectors against a
// behavioural data memory, plus hand-written timeout and reset sequences.
module tb_dmem_master;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_sign_mask;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [2:0]  mem_sign_mask;
    logic        mem_clk_stall;
    logic [31:0] mem_read_data;

    dmem_master #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_write      (req_write),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .i_req_sign_mask  (req_sign_mask),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_resp_fault     (resp_fault),
        .o_mem_addr       (mem_addr),
        .o_mem_write_data (mem_write_data),
        .o_mem_memread    (mem_memread),
        .o_mem_memwrite   (mem_memwrite),
        .o_mem_sign_mask  (mem_sign_mask),
        .i_mem_clk_stall  (mem_clk_stall),
        .i_mem_read_data  (mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural memory + strobe monitor ----------------
    logic        mdl_en;
    logic        mdl_stall;
    logic        man_stall;
    int          mdl_cnt;
    logic [31:0] mdl_pending;
    logic [31:0] iss_addr;
    logic [31:0] mem_arr [logic [31:0]];
    int          n_rd, n_wr, stable_bad;
    logic [31:0] rd_addr [4];
    logic [2:0]  rd_mask [4];
    logic [31:0] wr_addr, wr_data;
    logic [2:0]  wr_mask;

    assign mem_clk_stall = mdl_stall | man_stall;

    // Stall rises after the edge that samples the strobe and falls two edges
    // later, with read data valid from the fall.
    initial begin
        mdl_stall = 1'b0; mdl_cnt = 0; mdl_pending = 32'h0; iss_addr = 32'h0;
        mem_read_data = 32'h0; n_rd = 0; n_wr = 0; stable_bad = 0;
        wr_addr = 32'h0; wr_data = 32'h0; wr_mask = 3'b000;
        forever begin
            @(negedge clk);
            if (mdl_cnt == 3) begin
                mdl_stall = 1'b1; mdl_cnt = 2;
            end else if (mdl_cnt == 2) begin
                mdl_cnt = 1;
            end else if (mdl_cnt == 1) begin
                mdl_stall = 1'b0; mem_read_data = mdl_pending; mdl_cnt = 0;
                if (mem_addr !== iss_addr) stable_bad++;
            end
            if (mem_memread === 1'b1) begin
                rd_addr[n_rd % 4] = mem_addr;
                rd_mask[n_rd % 4] = mem_sign_mask;
                n_rd++;
                iss_addr = mem_addr;
                if (mem_arr.exists({mem_addr[31:2], 2'b00}))
                    mdl_pending = mem_arr[{mem_addr[31:2], 2'b00}];
                else
                    mdl_pending = 32'h0;
                if (mdl_en) mdl_cnt = 3;
            end
            if (mem_memwrite === 1'b1) begin
                wr_addr = mem_addr; wr_data = mem_write_data; wr_mask = mem_sign_mask;
                n_wr++;
                iss_addr = mem_addr;
                mdl_pending = 32'h0;
                if (mdl_en) mdl_cnt = 3;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge; report latency in edges after the
    // accepting edge (-1 if no response within the bound).
    task automatic run_txn(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] mask,
                           output int lat, output logic [31:0] rdata,
                           output logic fault, output logic pulse_ok);
        int k;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_sign_mask = mask;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; rdata = 32'h0; fault = 1'b0; k = 1;
        while (lat < 0 && k <= 60) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) begin
                lat = k; rdata = resp_rdata; fault = resp_fault;
            end
            k++;
        end
        @(posedge clk);
        #1 pulse_ok = (resp_valid === 1'b0);
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  mask;
        logic [31:0] mw0;
        logic [31:0] mw1;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_nrd;
        int          exp_nwr;
        logic [31:0] exp_a0;
        logic [2:0]  exp_m0;
    } vec_t;

    vec_t        vecs [13];
    int          lat;
    logic [31:0] rdata;
    logic        fault, pulse_ok;
    int          rd0, wr0, sb0;
    logic [31:0] base;

    initial begin
        //          wr    addr          wdata         mask    mw0           mw1           rdata         flt   lat nrd nwr a0            m0
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,        3'b010, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 4,  1,  0,  32'h0000_0010, 3'b010};
        vecs[1]  = '{1'b0, 32'h0000_0011, 32'h0,        3'b010, 32'h44332211, 32'h88776655, 32'h55443322, 1'b0, 8,  2,  0,  32'h0000_0010, 3'b010};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,        3'b101, 32'h44332211, 32'h887766F5, 32'hFFFFF544, 1'b0, 8,  2,  0,  32'h0000_0010, 3'b010};
        vecs[3]  = '{1'b0, 32'h0000_0013, 32'h0,        3'b001, 32'h44332211, 32'h887766F5, 32'h0000F544, 1'b0, 8,  2,  0,  32'h0000_0010, 3'b010};
        vecs[4]  = '{1'b1, 32'h0000_2000, 32'h4,        3'b010, 32'h0,        32'h0,        32'h0,        1'b0, 4,  0,  1,  32'h0000_2000, 3'b010};
        vecs[5]  = '{1'b1, 32'h0000_2002, 32'h5,        3'b010, 32'h0,        32'h0,        32'h0,        1'b1, 1,  0,  0,  32'h0,         3'b000};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFE, 32'h0,        3'b010, 32'h0,        32'h0,        32'h0,        1'b1, 1,  0,  0,  32'h0,         3'b000};
        vecs[7]  = '{1'b0, 32'h0000_0012, 32'h0,        3'b101, 32'h80010000, 32'h0,        32'h80010000, 1'b0, 4,  1,  0,  32'h0000_0012, 3'b101};
        vecs[8]  = '{1'b0, 32'h0000_0017, 32'h0,        3'b000, 32'hA1B2C3D4, 32'h0,        32'hA1B2C3D4, 1'b0, 4,  1,  0,  32'h0000_0017, 3'b000};
        vecs[9]  = '{1'b0, 32'h0000_0016, 32'h0,        3'b010, 32'h44332211, 32'h88776655, 32'h66554433, 1'b0, 8,  2,  0,  32'h0000_0014, 3'b010};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'h0,        3'b001, 32'h0,        32'h0,        32'h0,        1'b1, 1,  0,  0,  32'h0,         3'b000};
        vecs[11] = '{1'b1, 32'h0000_2003, 32'h7,        3'b001, 32'h0,        32'h0,        32'h0,        1'b1, 1,  0,  0,  32'h0,         3'b000};
        vecs[12] = '{1'b1, 32'h0000_2002, 32'h0000BEEF, 3'b001, 32'h0,        32'h0,        32'h0,        1'b0, 4,  0,  1,  32'h0000_2002, 3'b001};

        mdl_en = 1'b1; man_stall = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_sign_mask = 3'b000;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   32'(req_ready),      32'h1);
        chk("rst_valid",   32'(resp_valid),     32'h0);
        chk("rst_fault",   32'(resp_fault),     32'h0);
        chk("rst_rdata",   resp_rdata,          32'h0);
        chk("rst_memread", 32'(mem_memread),    32'h0);
        chk("rst_memwr",   32'(mem_memwrite),   32'h0);
        chk("rst_addr",    mem_addr,            32'h0);
        chk("rst_mask",    32'(mem_sign_mask),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            base = {vecs[i].addr[31:2], 2'b00};
            mem_arr[base]         = vecs[i].mw0;
            mem_arr[base + 32'd4] = vecs[i].mw1;
            rd0 = n_rd; wr0 = n_wr; sb0 = stable_bad;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'h1);
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask,
                    lat, rdata, fault, pulse_ok);
            chk($sformatf("v%0d_latency", i), 32'(lat),   32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i),   rdata,      vecs[i].exp_rdata);
            chk($sformatf("v%0d_fault", i),   32'(fault), 32'(vecs[i].exp_fault));
            chk($sformatf("v%0d_pulse1", i),  32'(pulse_ok), 32'h1);
            chk($sformatf("v%0d_nreads", i),  32'(n_rd - rd0), 32'(vecs[i].exp_nrd));
            chk($sformatf("v%0d_nwrites", i), 32'(n_wr - wr0), 32'(vecs[i].exp_nwr));
            chk($sformatf("v%0d_addr_stable", i), 32'(stable_bad - sb0), 32'h0);
            if (vecs[i].exp_nrd > 0) begin
                chk($sformatf("v%0d_rd_addr0", i), rd_addr[rd0 % 4], vecs[i].exp_a0);
                chk($sformatf("v%0d_rd_mask0", i), 32'(rd_mask[rd0 % 4]), 32'(vecs[i].exp_m0));
            end
            if (vecs[i].exp_nrd == 2) begin
                chk($sformatf("v%0d_rd_addr1", i), rd_addr[(rd0 + 1) % 4], vecs[i].exp_a0 + 32'd4);
                chk($sformatf("v%0d_rd_mask1", i), 32'(rd_mask[(rd0 + 1) % 4]), 32'h2);
            end
            if (vecs[i].exp_nwr > 0) begin
                chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].exp_a0);
                chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].wdata);
                chk($sformatf("v%0d_wr_mask", i), 32'(wr_mask), 32'(vecs[i].exp_m0));
            end
        end

        // ---------------- timeout: memory never raises stall ----------------
        mdl_en = 1'b0;
        rd0 = n_rd;
        run_txn(1'b0, 32'h0000_0020, 32'h0, 3'b010, lat, rdata, fault, pulse_ok);
        chk("to_latency", 32'(lat),   32'(TO + 1));
        chk("to_fault",   32'(fault), 32'h1);
        chk("to_rdata",   rdata,      32'h0);
        chk("to_pulse1",  32'(pulse_ok), 32'h1);
        chk("to_nreads",  32'(n_rd - rd0), 32'h1);
        chk("to_idle_ready", 32'(req_ready), 32'h1);
        // A stall edge arriving after the timeout must hold off new requests.
        man_stall = 1'b1;
        @(posedge clk);
        #1;
        chk("late_stall_ready", 32'(req_ready),  32'h0);
        chk("late_stall_resp",  32'(resp_valid), 32'h0);
        man_stall = 1'b0;
        #1;
        chk("late_stall_release", 32'(req_ready), 32'h1);
        @(negedge clk);

        // ---------------- reset in WAIT_LO with stall high ----------------
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
        req_wdata = 32'h0; req_sign_mask = 3'b010;
        @(posedge clk);                 // accept
        #1 req_valid = 1'b0;
        @(posedge clk);                 // now in WAIT_HI
        #1 man_stall = 1'b1;
        @(posedge clk);                 // now in WAIT_LO
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_valid",   32'(resp_valid),    32'h0);
        chk("mr_fault",   32'(resp_fault),    32'h0);
        chk("mr_rdata",   resp_rdata,         32'h0);
        chk("mr_memread", 32'(mem_memread),   32'h0);
        chk("mr_addr",    mem_addr,           32'h0);
        chk("mr_wdata",   mem_write_data,     32'h0);
        chk("mr_mask",    32'(mem_sign_mask), 32'h0);
        chk("mr_ready_in_rst", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mr_ready_stall_hi", 32'(req_ready), 32'h0);
        man_stall = 1'b0;
        #1;
        chk("mr_ready_stall_lo", 32'(req_ready), 32'h1);
        @(negedge clk);

        // Recovery: a normal aligned load after the aborted one.
        mdl_en = 1'b1;
        mem_arr[32'h0000_0040] = 32'h1234_5678;
        run_txn(1'b0, 32'h0000_0040, 32'h0, 3'b010, lat, rdata, fault, pulse_ok);
        chk("rec_latency", 32'(lat),   32'h4);
        chk("rec_rdata",   rdata,      32'h1234_5678);
        chk("rec_fault",   32'(fault), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
